// File: rtl/blake2b_stream_ctrl_if.sv
// Bundle of the three channels around the blake2b stream controller:
//   - input byte stream   : in_valid/in_ready/in_data/in_bytes/in_last
//   - core handshake      : core_init/next/final, core_block, core_length, core_outlen,
//                           core_ready, core_digest, core_digest_valid
//   - digest output       : dig_valid/dig_ready/dig_data
// modport master : the controller side (drives in_ready, core_* requests and dig_*).
// modport slave  : the environment side (message source, hash core and digest sink).
interface blake2b_stream_ctrl_if #(
   parameter int unsigned IN_BYTES     = 8,
   parameter int unsigned DIGEST_BYTES = 64
);
   localparam int unsigned BYTES_W = $clog2(IN_BYTES) + 1;

   logic                      in_valid;
   logic                      in_ready;
   logic [IN_BYTES*8-1:0]     in_data;
   logic [BYTES_W-1:0]        in_bytes;
   logic                      in_last;

   logic                      core_init;
   logic                      core_next;
   logic                      core_final;
   logic [1023:0]             core_block;
   logic [127:0]              core_length;
   logic [6:0]                core_outlen;
   logic                      core_ready;
   logic [511:0]              core_digest;
   logic                      core_digest_valid;

   logic                      dig_valid;
   logic                      dig_ready;
   logic [DIGEST_BYTES*8-1:0] dig_data;

   modport master (
      input  in_valid, in_data, in_bytes, in_last,
      output in_ready,
      output core_init, core_next, core_final, core_block, core_length, core_outlen,
      input  core_ready, core_digest, core_digest_valid,
      output dig_valid, dig_data,
      input  dig_ready
   );

   modport slave (
      output in_valid, in_data, in_bytes, in_last,
      input  in_ready,
      input  core_init, core_next, core_final, core_block, core_length, core_outlen,
      output core_ready, core_digest, core_digest_valid,
      input  dig_valid, dig_data,
      output dig_ready
   );
endinterface

// File: rtl/blake2b_stream_ctrl.sv
// Message controller in front of a blake2b core. Packs an arbitrary-length byte stream into
// 1024-bit blocks, keeps the 128-bit byte counter, holds a full block back until it is known
// not to be the last one, zero-pads the final block, sequences init/next/final on the core and
// returns a DIGEST_BYTES digest over a valid/ready channel.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : blake2b_stream_ctrl_if.master (input stream, core handshake, digest output)
module blake2b_stream_ctrl #(
   parameter int unsigned IN_BYTES     = 8,
   parameter int unsigned DIGEST_BYTES = 64
) (
   input logic                   clk,
   input logic                   reset_n,
   blake2b_stream_ctrl_if.master bus
);
   localparam int unsigned BYTES_W = $clog2(IN_BYTES) + 1;
   localparam int unsigned DIG_W   = DIGEST_BYTES * 8;

   typedef enum logic [2:0] {
      StIdle, StInit, StFill, StFlush, StFinal, StWaitDig, StOut
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      fill_q, fill_d;     // 0..128 bytes buffered
   logic [127:0]    cnt_q, cnt_d;       // cumulative message bytes, wraps mod 2^128
   logic [1023:0]   buf_q, buf_d;
   logic [1023:0]   blk_q;              // block shown to the core since the last pulse
   logic [127:0]    len_q;
   logic            dig_valid_q, dig_valid_d;
   logic [DIG_W-1:0] dig_q, dig_d;

   logic               pulse_init, pulse_next, pulse_final;
   logic [BYTES_W-1:0] beat_bytes;
   logic               buf_full;
   logic               empty_last;
   logic               in_ready;
   logic               fire;

   // Only a last beat carries a partial count; oversize counts clamp to a full beat.
   always_comb begin
      beat_bytes = BYTES_W'(IN_BYTES);
      if (bus.in_last && (int'(bus.in_bytes) < int'(IN_BYTES))) begin
         beat_bytes = bus.in_bytes;
      end
   end

   assign buf_full   = (fill_q == 8'd128);
   // A zero-byte last beat on a full buffer closes the message without an extra empty block.
   assign empty_last = bus.in_valid && bus.in_last && (beat_bytes == '0);
   assign in_ready   = (state_q == StFill) && (!buf_full || empty_last);
   assign fire       = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      dig_valid_d = dig_valid_q;
      dig_d       = dig_q;
      pulse_init  = 1'b0;
      pulse_next  = 1'b0;
      pulse_final = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) state_d = StInit;
         end
         StInit: begin
            if (bus.core_ready) begin
               pulse_init = 1'b1;
               state_d    = StFill;
            end
         end
         StFill: begin
            if (fire) begin
               for (int k = 0; k < int'(IN_BYTES); k++) begin
                  if ((k < int'(beat_bytes)) && ((int'(fill_q) + k) < 128)) begin
                     buf_d[(int'(fill_q) + k)*8 +: 8] = bus.in_data[k*8 +: 8];
                  end
               end
               fill_d = fill_q + 8'(beat_bytes);
               cnt_d  = cnt_q + 128'(beat_bytes);
               if (bus.in_last) state_d = StFinal;
            end else if (buf_full && bus.in_valid) begin
               // More data exists, so the buffered block is not the last one.
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (bus.core_ready) begin
               pulse_next = 1'b1;
               buf_d      = '0;
               fill_d     = '0;
               state_d    = StFill;
            end
         end
         StFinal: begin
            if (bus.core_ready) begin
               pulse_final = 1'b1;
               state_d     = StWaitDig;
            end
         end
         StWaitDig: begin
            if (bus.core_digest_valid) begin
               dig_d       = bus.core_digest[511 -: DIG_W];
               dig_valid_d = 1'b1;
               state_d     = StOut;
            end
         end
         StOut: begin
            if (bus.dig_ready) begin
               dig_valid_d = 1'b0;
               cnt_d       = '0;
               fill_d      = '0;
               buf_d       = '0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         fill_q      <= '0;
         cnt_q       <= '0;
         buf_q       <= '0;
         blk_q       <= '0;
         len_q       <= '0;
         dig_valid_q <= 1'b0;
         dig_q       <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         cnt_q       <= cnt_d;
         buf_q       <= buf_d;
         dig_valid_q <= dig_valid_d;
         dig_q       <= dig_d;
         if (pulse_next || pulse_final) begin
            blk_q <= buf_q;
            len_q <= cnt_q;
         end
      end
   end

   // The pulse cycle shows the live buffer; afterwards the captured copy keeps it stable.
   assign bus.core_block  = (pulse_next || pulse_final) ? buf_q : blk_q;
   assign bus.core_length = (pulse_next || pulse_final) ? cnt_q : len_q;
   assign bus.core_outlen = 7'(DIGEST_BYTES);
   assign bus.core_init   = pulse_init;
   assign bus.core_next   = pulse_next;
   assign bus.core_final  = pulse_final;
   assign bus.in_ready    = in_ready;
   assign bus.dig_valid   = dig_valid_q;
   assign bus.dig_data    = dig_q;
endmodule

// File: tb/tb_blake2b_stream_ctrl.sv
module tb_blake2b_stream_ctrl;
   localparam int unsigned IN_BYTES     = 8;
   localparam int unsigned DIGEST_BYTES = 64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   blake2b_stream_ctrl_if #(.IN_BYTES(IN_BYTES), .DIGEST_BYTES(DIGEST_BYTES)) bif ();

   blake2b_stream_ctrl #(.IN_BYTES(IN_BYTES), .DIGEST_BYTES(DIGEST_BYTES)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif.master)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // ---------------- BLAKE2b reference arithmetic ----------------
   logic [63:0] iv [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                           64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                           64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
   int sigma [10][16] = '{
      '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
      '{14, 10, 4, 8, 9, 15, 13, 6, 1, 12, 0, 2, 11, 7, 5, 3},
      '{11, 8, 12, 0, 5, 2, 15, 13, 10, 14, 3, 6, 7, 1, 9, 4},
      '{7, 9, 3, 1, 13, 12, 11, 14, 2, 6, 5, 10, 4, 0, 15, 8},
      '{9, 0, 5, 7, 2, 4, 10, 15, 14, 1, 11, 12, 6, 8, 3, 13},
      '{2, 12, 6, 10, 0, 11, 8, 3, 4, 13, 7, 5, 15, 14, 1, 9},
      '{12, 5, 1, 15, 14, 13, 4, 10, 0, 7, 6, 3, 9, 2, 8, 11},
      '{13, 11, 7, 14, 12, 1, 3, 9, 5, 0, 15, 4, 8, 6, 2, 10},
      '{6, 15, 14, 9, 11, 3, 0, 8, 12, 2, 13, 7, 1, 4, 10, 5},
      '{10, 2, 8, 4, 7, 6, 1, 5, 15, 11, 9, 14, 3, 12, 13, 0}};
   int ga [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int gb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
   int gc [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
   int gd [8] = '{12, 13, 14, 15, 15, 12, 13, 14};

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] init_h(input int outlen);
      logic [511:0] hs;
      for (int i = 0; i < 8; i++) hs[64*i +: 64] = iv[i];
      hs[63:0] = hs[63:0] ^ 64'h01010000 ^ 64'(outlen);
      return hs;
   endfunction

   function automatic logic [511:0] b2_compress(input logic [511:0] hs, input logic [1023:0] blk,
                                                input logic [127:0] t, input bit f);
      logic [63:0] v [16];
      logic [63:0] m [16];
      logic [63:0] x, y;
      logic [511:0] r;
      int a, b, c, d;
      for (int i = 0; i < 8; i++) begin
         v[i]     = hs[64*i +: 64];
         v[i + 8] = iv[i];
      end
      for (int i = 0; i < 16; i++) m[i] = blk[64*i +: 64];
      v[12] = v[12] ^ t[63:0];
      v[13] = v[13] ^ t[127:64];
      if (f) v[14] = ~v[14];
      for (int rr = 0; rr < 12; rr++) begin
         for (int g = 0; g < 8; g++) begin
            a = ga[g]; b = gb[g]; c = gc[g]; d = gd[g];
            x = m[sigma[rr % 10][2*g]];
            y = m[sigma[rr % 10][2*g + 1]];
            v[a] = v[a] + v[b] + x;  v[d] = rotr(v[d] ^ v[a], 32);
            v[c] = v[c] + v[d];      v[b] = rotr(v[b] ^ v[c], 24);
            v[a] = v[a] + v[b] + y;  v[d] = rotr(v[d] ^ v[a], 16);
            v[c] = v[c] + v[d];      v[b] = rotr(v[b] ^ v[c], 63);
         end
      end
      for (int i = 0; i < 8; i++) r[64*i +: 64] = hs[64*i +: 64] ^ v[i] ^ v[i + 8];
      return r;
   endfunction

   // Digest byte k (little-endian state order) lands at [511-8k -: 8].
   function automatic logic [511:0] to_digest(input logic [511:0] hs);
      logic [511:0] dg;
      for (int k = 0; k < 64; k++) dg[511 - 8*k -: 8] = hs[8*k +: 8];
      return dg;
   endfunction

   // ---------------- message reference model ----------------
   logic [7:0] msg_q [$];

   function automatic int num_blocks();
      return (msg_q.size() == 0) ? 1 : (msg_q.size() + 127) / 128;
   endfunction

   function automatic logic [1023:0] exp_block(input int b);
      logic [1023:0] blk = '0;
      for (int j = 0; j < 128; j++) begin
         if (b*128 + j < msg_q.size()) blk[8*j +: 8] = msg_q[b*128 + j];
      end
      return blk;
   endfunction

   function automatic logic [127:0] exp_len(input int b);
      return (b < num_blocks() - 1) ? 128'(128*(b + 1)) : 128'(msg_q.size());
   endfunction

   function automatic logic [511:0] ref_digest();
      logic [511:0] hs = init_h(DIGEST_BYTES);
      int nb = num_blocks();
      for (int b = 0; b < nb; b++) hs = b2_compress(hs, exp_block(b), exp_len(b), b == nb - 1);
      return to_digest(hs);
   endfunction

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int lane = 0;
      tests_run++;
      for (int w = 15; w >= 0; w--) if (obs[64*w +: 64] !== exp[64*w +: 64]) lane = w;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: lane %0d observed %h required %h", tag, lane, obs[64*lane +: 64],
                exp[64*lane +: 64]);
      end
   endtask

   // ---------------- behavioural core + pulse monitor ----------------
   int unsigned   busy_cnt  = 0;
   bit            pend_dig  = 1'b0;
   bit            force_low = 1'b0;
   logic [511:0]  core_h;
   int            rec_kind [$];    // 0 init, 1 next, 2 final
   logic [1023:0] rec_blk [$];
   logic [127:0]  rec_len [$];

   assign bif.core_ready = (busy_cnt == 0) && !pend_dig && !force_low;

   initial begin
      bit p_init, p_next, p_final;
      logic [1023:0] s_blk;
      logic [127:0]  s_len;
      bif.core_digest       = '0;
      bif.core_digest_valid = 1'b0;
      forever begin
         @(negedge clk);
         p_init  = bif.core_init;
         p_next  = bif.core_next;
         p_final = bif.core_final;
         s_blk   = bif.core_block;
         s_len   = bif.core_length;
         if (reset_n && (p_init || p_next || p_final)) begin
            check("pulse_needs_ready", 1024'(bif.core_ready), 1024'(1));
            check("pulse_onehot", 1024'(int'(p_init) + int'(p_next) + int'(p_final)), 1024'(1));
            rec_kind.push_back(p_init ? 0 : (p_next ? 1 : 2));
            rec_blk.push_back(s_blk);
            rec_len.push_back(s_len);
         end
         @(posedge clk);
         #1;
         if (!reset_n) begin
            busy_cnt = 0; pend_dig = 1'b0; bif.core_digest_valid = 1'b0;
         end else begin
            bif.core_digest_valid = 1'b0;
            if (p_init) begin
               core_h   = init_h(int'(bif.core_outlen));
               busy_cnt = $urandom_range(0, 2);
            end else if (p_next) begin
               core_h   = b2_compress(core_h, s_blk, s_len, 1'b0);
               busy_cnt = $urandom_range(0, 2);
            end else if (p_final) begin
               core_h   = b2_compress(core_h, s_blk, s_len, 1'b1);
               busy_cnt = $urandom_range(0, 3);
               pend_dig = 1'b1;
            end else if (busy_cnt > 0) begin
               busy_cnt--;
            end else if (pend_dig) begin
               bif.core_digest       = to_digest(core_h);
               bif.core_digest_valid = 1'b1;
               pend_dig              = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [511:0] last_digest;

   task automatic drive_beat(input logic [63:0] data, input logic [3:0] nbytes, input bit last,
                             input bit stall);
      bit acc = 1'b0;
      bif.in_valid = 1'b1;
      bif.in_data  = data;
      bif.in_bytes = nbytes;
      bif.in_last  = last;
      if (stall) begin
         repeat (10) begin
            @(negedge clk);
            check("flush_stall_in_ready", 1024'(bif.in_ready), 1024'(0));
            @(posedge clk);
            #1;
         end
         check("flush_stall_no_next", 1024'(rec_kind.size()), 1024'(1));
         force_low = 1'b0;
      end
      for (int c = 0; c < 300 && !acc; c++) begin
         @(negedge clk);
         if (bif.in_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!acc) check("beat_accept_timeout", 1024'(0), 1024'(1));
   endtask

   task automatic run_msg(input bit empty_pref, input bit stall_flush, input int dig_dly);
      int L = msg_q.size();
      int pos = 0;
      int nbeats, vc, lb;
      bit use_empty, got;
      logic [63:0] data;
      logic [3:0]  nb;
      logic [511:0] d0;
      rec_kind.delete(); rec_blk.delete(); rec_len.delete();
      use_empty = (L % 8 == 0) && ((L == 0) || empty_pref || ($urandom_range(0, 1) == 1));
      nbeats    = use_empty ? L / 8 + 1 : (L + 7) / 8;
      lb        = use_empty ? 0 : L - 8*(nbeats - 1);
      for (int b = 0; b < nbeats; b++) begin
         bit last = (b == nbeats - 1);
         if ($urandom_range(0, 3) == 0) begin
            bif.in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         vc   = last ? lb : 8;
         data = {$urandom, $urandom};
         for (int k = 0; k < vc; k++) data[8*k +: 8] = msg_q[pos + k];
         pos += vc;
         if (!last) nb = 4'($urandom_range(0, 15));
         else if (lb == 8) nb = 4'($urandom_range(8, 15));
         else nb = 4'(lb);
         if (stall_flush && b == 16) force_low = 1'b1;
         drive_beat(data, nb, last, stall_flush && b == 16);
      end
      bif.in_valid = 1'b0;
      bif.in_last  = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (bif.dig_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("digest_timeout", 1024'(0), 1024'(1));
         return;
      end
      d0 = bif.dig_data;
      repeat (dig_dly) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("dig_hold_valid", 1024'(bif.dig_valid), 1024'(1));
         check("dig_hold_data", 1024'(bif.dig_data), 1024'(d0));
      end
      bif.dig_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.dig_ready = 1'b0;
      check("dig_cleared", 1024'(bif.dig_valid), 1024'(0));
      check("digest", 1024'(d0), 1024'(ref_digest()));
      last_digest = d0;
      check("pulse_count", 1024'(rec_kind.size()), 1024'(num_blocks() + 1));
      if (rec_kind.size() == num_blocks() + 1) begin
         check("first_is_init", 1024'(rec_kind[0]), 1024'(0));
         for (int i = 1; i <= num_blocks(); i++) begin
            check("pulse_kind", 1024'(rec_kind[i]), 1024'((i < num_blocks()) ? 1 : 2));
            check("core_length", 1024'(rec_len[i]), 1024'(exp_len(i - 1)));
            check("core_block", rec_blk[i], exp_block(i - 1));
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_in_ready"}, 1024'(bif.in_ready), 1024'(0));
      check({tag, "_pulses"}, 1024'({bif.core_init, bif.core_next, bif.core_final}), 1024'(0));
      check({tag, "_block"}, bif.core_block, 1024'(0));
      check({tag, "_length"}, 1024'(bif.core_length), 1024'(0));
      check({tag, "_dig_valid"}, 1024'(bif.dig_valid), 1024'(0));
      check({tag, "_dig_data"}, 1024'(bif.dig_data), 1024'(0));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.in_bytes  = '0;
      bif.in_last   = 1'b0;
      bif.dig_ready = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      check("outlen", 1024'(bif.core_outlen), 1024'(64));
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // "abc"
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(1'b0, 1'b0, 0);
      check("abc_prefix", 1024'(last_digest[511:448]), 1024'(64'hba80a53f981c4d0d));
      check("abc_suffix", 1024'(last_digest[31:0]), 1024'(32'hd4009923));
      check("abc_block", rec_blk[rec_blk.size() - 1], 1024'(24'h636261));

      // Empty message
      msg_q.delete();
      run_msg(1'b0, 1'b0, 1);
      check("empty_prefix", 1024'(last_digest[511:448]), 1024'(64'h786a02f742015903));

      // Exactly 128 bytes closed by an empty last beat
      msg_q.delete();
      for (int i = 0; i < 128; i++) msg_q.push_back(8'($urandom));
      run_msg(1'b1, 1'b0, 0);

      // 129 bytes
      msg_q.delete();
      for (int i = 0; i < 129; i++) msg_q.push_back(8'($urandom));
      run_msg(1'b0, 1'b0, 0);

      // Core stalls during the flush; digest consumer stalls 5 cycles
      msg_q.delete();
      for (int i = 0; i < 200; i++) msg_q.push_back(8'($urandom));
      run_msg(1'b0, 1'b1, 5);

      // Reset mid-block, then "abc" again
      for (int b = 0; b < 5; b++) drive_beat({$urandom, $urandom}, 4'd0, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      bif.in_valid = 1'b0;
      busy_cnt     = 0;
      pend_dig     = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(1'b0, 1'b0, 0);
      check("post_reset_abc", 1024'(last_digest[511:448]), 1024'(64'hba80a53f981c4d0d));

      // Random lengths around block boundaries
      for (int n = 0; n < 20; n++) begin
         int len;
         case ($urandom_range(0, 3))
            0:       len = 128 * $urandom_range(1, 3);
            1:       len = 128 * $urandom_range(1, 3) + $urandom_range(0, 1) * 2 - 1;
            default: len = $urandom_range(0, 400);
         endcase
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         run_msg(1'b0, 1'b0, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/blake2b_stream_ctrl.md
Name: blake2b_stream_ctrl

Overview:
- Parametrised message controller in front of the blake2b core.
- Accepts a byte stream of arbitrary length over a valid/ready interface and packs it into 1024-bit blocks.
- Tracks the 128-bit byte counter, holds back each full block until it is known not to be the last, and zero-pads the final block.
- Drives the core's init/next/final handshake and returns a truncated digest of DIGEST_BYTES via a valid/ready output.

Parameters:
- IN_BYTES, 8, bytes per input beat; legal values 1, 2, 4, 8, 16 (must divide 128).
- DIGEST_BYTES, 64, digest length in bytes, 1..64; passed to the core at init and used as the output width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_data  in  IN_BYTES*8  beat data; byte k = in_data[8k+7:8k], lower k comes earlier in the message.
- in_bytes  in  $clog2(IN_BYTES)+1  valid bytes in beat (0..IN_BYTES); sampled only when in_last=1, else the beat is full.
- in_last  in  1  final beat of message.
- core_init  out  1  one-cycle pulse, start new hash.
- core_next  out  1  one-cycle pulse, compress non-final block.
- core_final  out  1  one-cycle pulse, compress final block.
- core_block  out  1024  block to core; message byte i of block at [8i+7:8i].
- core_length  out  128  cumulative message bytes including the current block.
- core_outlen  out  7  DIGEST_BYTES.
- core_ready  in  1  core idle and able to take a pulse.
- core_digest  in  512  core digest; byte 0 at [511:504].
- core_digest_valid  in  1  core_digest valid.
- dig_valid  out  1  digest available.
- dig_ready  in  1  digest consumed when dig_valid&&dig_ready.
- dig_data  out  DIGEST_BYTES*8  core_digest[511 -: DIGEST_BYTES*8], latched.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 (in_ready, core_init/next/final, core_block, core_length, dig_valid, dig_data). Buffer fill count (0..128) and byte counter cleared. Deassertion is taken synchronously.
- Every core pulse is emitted only in a cycle where core_ready=1, and lasts exactly one cycle.
- FSM states: IDLE, INIT, FILL, FLUSH, FINAL, WAIT_DIG, OUT.
  - IDLE: in_ready=0. On in_valid, go to INIT.
  - INIT: wait for core_ready, pulse core_init, go to FILL.
  - FILL: in_ready=1 while fill<128.
    - Accepted beat writes bytes at offset fill; fill and the counter add IN_BYTES, or in_bytes when last.
    - Accepted in_last → FINAL.
    - If fill==128 and in_valid: in_ready=0, go to FLUSH (this beat is held, not accepted).
  - FLUSH: wait for core_ready, pulse core_next with core_length=counter, clear buffer to zero, fill=0, return to FILL; the held beat is accepted the following cycle.
  - FINAL: unused bytes are already zero. Wait for core_ready, pulse core_final with core_length=counter, go to WAIT_DIG.
  - WAIT_DIG: on core_digest_valid, latch dig_data, set dig_valid, go to OUT.
  - OUT: hold dig_valid and dig_data stable until dig_ready. Then clear dig_valid, counter and fill, and go to IDLE.
- Block boundaries:
  - A block exactly 128 bytes is never sent with core_next until a further beat arrives.
  - Empty message (single beat, in_last, in_bytes=0) → one all-zero block, core_final with core_length=0.
  - Message length multiple of 128 ending with an in_bytes=0 last beat → the final block is the full buffered block, with no extra zero block.
- in_bytes>IN_BYTES with in_last is clamped to IN_BYTES.
- Counter is 128-bit and wraps modulo 2^128 (no overflow flag).
- core_block and core_length are held stable from the pulse until the next pulse.
- Minimum latency: last beat accepted → core_final pulse 1 cycle later if core_ready; digest output 1 cycle after core_digest_valid.
- Reset mid-message abandons all state immediately; the core is re-inited on the next message.

Test Plan:
- IN_BYTES=8, DIGEST_BYTES=64; beat "abc" (in_bytes=3, in_last) → one core_init, one core_final, core_length=3, block[23:0]=0x636261, rest 0; with the reference core, dig_data begins 0xba80a53f981c4d0d and ends 0xd4009923.
- Empty message → core_final with core_length=0 and an all-zero block; digest begins 0x786a02f742015903.
- 128-byte message as 16 full beats plus a last beat with in_bytes=0 → no core_next, one core_final with core_length=128.
- 129-byte message → core_next (length 128) then core_final (length 129, block byte0 = msg[128], rest 0).
- core_ready held low 10 cycles during FLUSH → in_ready stays 0, no data lost; dig_ready held low 5 cycles → dig_data stable.
- reset_n pulsed low mid-block → all outputs 0 immediately; the next message "abc" hashes correctly.
